// File: rtl/adder_seq_pkg.sv
// Shared constants and state encoding for the digit-serial adder sequencer.
// Optional subtract mode is enabled by defining ADDER_SEQ_SUB_EN.
package adder_seq_pkg;

  localparam int DIGIT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width able to represent 0..num_digits without wrapping.
  function automatic int cnt_width(input int num_digits);
    return (num_digits < 1) ? 1 : $clog2(num_digits + 1);
  endfunction

endpackage

// File: rtl/adder_digit_slice.sv
// Combinational DIGIT_W-bit adder with carry-in, built as a chain of full adders.
module adder_digit_slice
  import adder_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);

  logic [DIGIT_W:0] carry_chain;

  assign carry_chain[0] = cin;

  generate
    for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_fa
      logic half_sum;
      assign half_sum            = a[gi] ^ b[gi];
      assign s[gi]               = half_sum ^ carry_chain[gi];
      assign carry_chain[gi + 1] = (a[gi] & b[gi]) | (half_sum & carry_chain[gi]);
    end
  endgenerate

  assign cout = carry_chain[DIGIT_W];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Digit-serial WIDTH-bit adder: one DIGIT_W-bit digit per cycle, LSB first, valid/ready on both sides.
// Define ADDER_SEQ_SUB_EN to add a `sub` input selecting a - b (two's complement via inverted b, carry-in 1).
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ADDER_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NUM_DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W      = cnt_width(NUM_DIGITS);

  generate
    if ((WIDTH % DIGIT_W) != 0 || WIDTH < DIGIT_W) begin : g_bad_width
      $error("adder_seq_ctrl: WIDTH must be a positive multiple of DIGIT_W");
    end
  endgenerate

  state_e             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               carry_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               sub_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic [WIDTH-1:0]   sum_next;
  logic               cout_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic               busy_reg;

  logic               sub_in;
  logic               init_carry;
  logic               last_digit;

  logic [DIGIT_W-1:0] a_dig [NUM_DIGITS];
  logic [DIGIT_W-1:0] b_dig [NUM_DIGITS];
  logic [DIGIT_W-1:0] a_sel;
  logic [DIGIT_W-1:0] b_sel;
  logic [DIGIT_W-1:0] b_slice;
  logic [DIGIT_W-1:0] slice_s;
  logic               slice_cout;

`ifdef ADDER_SEQ_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Subtraction is a + ~b + 1, so the initial carry doubles as the "+1".
  assign init_carry = sub_in;
  assign last_digit = (cnt_reg == CNT_W'(NUM_DIGITS - 1));

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
      assign a_dig[gi] = a_reg[gi*DIGIT_W +: DIGIT_W];
      assign b_dig[gi] = b_reg[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cnt_reg == CNT_W'(i)) begin
        a_sel = a_dig[i];
        b_sel = b_dig[i];
      end
    end
  end

  assign b_slice = sub_reg ? ~b_sel : b_sel;

  adder_digit_slice u_slice (
    .a    (a_sel),
    .b    (b_slice),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Only the selected digit is replaced; higher digits keep their old value.
  always_comb begin
    sum_next = sum_reg;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cnt_reg == CNT_W'(i)) begin
        sum_next[i*DIGIT_W +: DIGIT_W] = slice_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sub_reg       <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_reg        <= a;
            b_reg        <= b;
            sub_reg      <= sub_in;
            carry_reg    <= init_carry;
            cnt_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= slice_cout;
          if (last_digit) begin
            cout_reg      <= slice_cout;
            cnt_reg       <= '0;
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          cnt_reg       <= '0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule
